// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access size codes,
// FSM state encoding and the alignment rule applied to every request.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // An access is naturally aligned when the low address bits below its size are zero.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lane);
        logic bad;
        case (size)
            SZ_H:    bad = lane[0];
            SZ_W:    bad = |lane[1:0];
            SZ_D:    bad = |lane[2:0];
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane steering for one doubleword: load extraction with sign/zero
// extension, and the read-modify-write merge for partial stores.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [63:0] i_dword,
    input  logic [2:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_load,
    output logic [63:0] o_merged
);

    logic [63:0] w_shift;
    logic [63:0] w_wshift;
    logic [7:0]  w_bytes;
    logic [7:0]  w_bmask;
    logic [63:0] w_bits;

    always_comb begin
        w_shift = i_dword >> {i_lane, 3'b000};
        o_load  = '0;
        case (i_size)
            SZ_B:    o_load = i_unsigned ? {56'd0, w_shift[7:0]}
                                         : {{56{w_shift[7]}}, w_shift[7:0]};
            SZ_H:    o_load = i_unsigned ? {48'd0, w_shift[15:0]}
                                         : {{48{w_shift[15]}}, w_shift[15:0]};
            SZ_W:    o_load = i_unsigned ? {32'd0, w_shift[31:0]}
                                         : {{32{w_shift[31]}}, w_shift[31:0]};
            default: o_load = w_shift;
        endcase
    end

    always_comb begin
        w_bytes = '0;
        case (i_size)
            SZ_B:    w_bytes = 8'h01;
            SZ_H:    w_bytes = 8'h03;
            SZ_W:    w_bytes = 8'h0F;
            default: w_bytes = 8'hFF;
        endcase
        w_bmask = w_bytes << i_lane;
        w_bits  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            w_bits[i*8 +: 8] = {8{w_bmask[i]}};
        end
        w_wshift = i_wdata << {i_lane, 3'b000};
        o_merged = (i_dword & ~w_bits) | (w_wshift & w_bits);
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request in flight, fixed latency,
// doubleword-organised store committed on the edge that enters RESP.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_DW = 128,
    parameter int LATENCY  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDXW = (DEPTH_DW > 1) ? $clog2(DEPTH_DW) : 1;
    localparam int CW   = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

    state_e        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_write;
    logic [63:0]   r_addr;
    logic [63:0]   r_wdata;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic [63:0]   r_mem [DEPTH_DW];

    logic          w_idle;
    logic          w_accept;
    logic          w_commit;
    logic          w_write;
    logic [63:0]   w_addr;
    logic [63:0]   w_wdata;
    logic [1:0]    w_size;
    logic          w_unsigned;
    logic [IDXW-1:0] w_idx;
    logic          w_range_err;
    logic          w_err;
    logic [63:0]   w_load;
    logic [63:0]   w_merged;

    assign w_idle     = (r_state == IDLE);
    assign req_ready  = w_idle;
    assign resp_valid = (r_state == RESP);
    assign w_accept   = w_idle & req_valid;

    // With LATENCY == 1 the commit edge is the acceptance edge, so the commit
    // datapath reads the live request in IDLE and the latched copy otherwise.
    assign w_write    = w_idle ? req_write    : r_write;
    assign w_addr     = w_idle ? req_addr     : r_addr;
    assign w_wdata    = w_idle ? req_wdata    : r_wdata;
    assign w_size     = w_idle ? req_size     : r_size;
    assign w_unsigned = w_idle ? req_unsigned : r_unsigned;

    assign w_commit = (w_accept && (LATENCY == 1)) ||
                      ((r_state == BUSY) && (r_cnt == '0));

    assign w_idx       = w_addr[IDXW+2:3];
    assign w_range_err = (w_addr[63:3] >= 61'(DEPTH_DW));
    assign w_err       = w_range_err | misaligned(w_size, w_addr[2:0]);

    dmem_lane_align u_align (
        .i_dword    (r_mem[w_idx]),
        .i_lane     (w_addr[2:0]),
        .i_size     (w_size),
        .i_unsigned (w_unsigned),
        .i_wdata    (w_wdata),
        .o_load     (w_load),
        .o_merged   (w_merged)
    );

    always_ff @(posedge clk) begin
        if (reset && w_commit && w_write && !w_err) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        if (LATENCY == 1) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= BUSY;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_commit) begin
                resp_err   <= w_err;
                resp_rdata <= (w_err || w_write) ? 64'd0 : w_load;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main
// scenarios and a LATENCY=1 instance checked against a byte-array model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        resp_ready = 1'b1;

    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [63:0] resp_rdata;

    logic        req_valid1 = 1'b0, req_write1 = 1'b0, req_unsigned1 = 1'b0;
    logic [63:0] req_addr1 = '0, req_wdata1 = '0;
    logic [1:0]  req_size1 = '0;
    logic        req_ready1, resp_valid1, resp_err1;
    logic [63:0] resp_rdata1;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] model [1024];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_DW(128), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH_DW(128), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
        .req_addr(req_addr1), .req_wdata(req_wdata1), .req_size(req_size1),
        .req_unsigned(req_unsigned1), .resp_valid(resp_valid1),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata1), .resp_err(resp_err1)
    );

    task automatic set_req(input bit l1, input bit v, input bit wr, input logic [63:0] a,
                           input logic [63:0] d, input logic [1:0] sz, input bit un);
        if (l1) begin
            req_valid1 = v; req_write1 = wr; req_addr1 = a;
            req_wdata1 = d; req_size1 = sz; req_unsigned1 = un;
        end else begin
            req_valid = v; req_write = wr; req_addr = a;
            req_wdata = d; req_size = sz; req_unsigned = un;
        end
    endtask

    // Issues one request, scrambles the inputs after acceptance, and returns
    // the response together with the accept-to-valid latency in cycles.
    task automatic do_req(input bit l1, input bit wr, input logic [63:0] a, input logic [63:0] d,
                          input logic [1:0] sz, input bit un,
                          output logic [63:0] rd, output logic er, output int lat);
        @(negedge clk);
        set_req(l1, 1'b1, wr, a, d, sz, un);
        @(posedge clk); #1;
        set_req(l1, 1'b0, ~wr, ~a, ~d, ~sz, ~un);
        lat = 1;
        while (!(l1 ? resp_valid1 : resp_valid) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = l1 ? resp_rdata1 : resp_rdata;
        er = l1 ? resp_err1 : resp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        n_cmp++; if (resp_rdata !== 64'd0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
        n_cmp++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", resp_err); end
        n_cmp++; if (req_ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready1 got=%b exp=1", req_ready1); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_double();
        logic [63:0] rd; logic er; int lat;
        do_req(1'b0, 1'b1, 64'h40, 64'h1122334455667788, 2'b11, 1'b0, rd, er, lat);
        n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL st_dbl_latency got=%0d exp=2", lat); end
        n_cmp++; if (er !== 1'b0 || rd !== 64'd0) begin n_fail++; $display("FAIL st_dbl_resp got=%b/%h exp=0/0", er, rd); end
        do_req(1'b0, 1'b0, 64'h40, 64'd0, 2'b11, 1'b0, rd, er, lat);
        n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL ld_dbl_latency got=%0d exp=2", lat); end
        n_cmp++; if (rd !== 64'h1122334455667788) begin n_fail++; $display("FAIL ld_dbl_rdata got=%h exp=1122334455667788", rd); end
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL ld_dbl_err got=%b exp=0", er); end
    endtask

    task automatic test_byte();
        logic [63:0] rd; logic er; int lat;
        do_req(1'b0, 1'b1, 64'h43, 64'h00000000000000AB, 2'b00, 1'b0, rd, er, lat);
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL st_byte_err got=%b exp=0", er); end
        do_req(1'b0, 1'b0, 64'h43, 64'd0, 2'b00, 1'b0, rd, er, lat);
        n_cmp++; if (rd !== 64'hFFFFFFFFFFFFFFAB) begin n_fail++; $display("FAIL ld_byte_signed got=%h exp=ffffffffffffffab", rd); end
        do_req(1'b0, 1'b0, 64'h43, 64'd0, 2'b00, 1'b1, rd, er, lat);
        n_cmp++; if (rd !== 64'h00000000000000AB) begin n_fail++; $display("FAIL ld_byte_unsigned got=%h exp=ab", rd); end
        do_req(1'b0, 1'b0, 64'h42, 64'd0, 2'b01, 1'b0, rd, er, lat);
        n_cmp++; if (rd !== 64'hFFFFFFFFFFFFAB66) begin n_fail++; $display("FAIL ld_half_signed got=%h exp=ffffffffffffab66", rd); end
        do_req(1'b0, 1'b0, 64'h40, 64'd0, 2'b11, 1'b1, rd, er, lat);
        n_cmp++; if (rd !== 64'h11223344AB667788) begin n_fail++; $display("FAIL ld_dbl_merged got=%h exp=11223344ab667788", rd); end
    endtask

    task automatic test_errors();
        logic [63:0] rd; logic er; int lat;
        do_req(1'b0, 1'b1, 64'h402, 64'h000000000000BEEF, 2'b01, 1'b0, rd, er, lat);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL st_range_err got=%b exp=1", er); end
        do_req(1'b0, 1'b1, 64'h42, 64'h00000000CAFEBABE, 2'b10, 1'b0, rd, er, lat);
        n_cmp++; if (er !== 1'b1 || rd !== 64'd0) begin n_fail++; $display("FAIL st_misalign got=%b/%h exp=1/0", er, rd); end
        do_req(1'b0, 1'b0, 64'h42, 64'd0, 2'b10, 1'b0, rd, er, lat);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL ld_misalign_err got=%b exp=1", er); end
        n_cmp++; if (rd !== 64'd0) begin n_fail++; $display("FAIL ld_misalign_rdata got=%h exp=0", rd); end
        do_req(1'b0, 1'b0, 64'h400, 64'd0, 2'b11, 1'b0, rd, er, lat);
        n_cmp++; if (er !== 1'b1 || rd !== 64'd0) begin n_fail++; $display("FAIL ld_range got=%b/%h exp=1/0", er, rd); end
        do_req(1'b0, 1'b0, 64'h40, 64'd0, 2'b11, 1'b0, rd, er, lat);
        n_cmp++; if (rd !== 64'h11223344AB667788 || er !== 1'b0) begin n_fail++; $display("FAIL mem_unchanged got=%h exp=11223344ab667788", rd); end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        resp_ready = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 64'h40, 64'd0, 2'b11, 1'b0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b1, 64'h8, 64'hFFFF, 2'b00, 1'b1);
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL bp_latency got=%0d exp=2", lat); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (resp_valid !== 1'b1 || resp_rdata !== 64'h11223344AB667788 ||
                resp_err !== 1'b0 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got v=%b d=%h e=%b rdy=%b exp v=1 d=11223344ab667788 e=0 rdy=0",
                         i, resp_valid, resp_rdata, resp_err, req_ready);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", resp_valid, req_ready); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd; logic er; int lat;
        do_req(1'b0, 1'b1, 64'h8, 64'h0123456789ABCDEF, 2'b11, 1'b0, rd, er, lat);
        do_req(1'b0, 1'b0, 64'h8, 64'd0, 2'b11, 1'b0, rd, er, lat);
        n_cmp++; if (rd !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL rm_preload got=%h exp=0123456789abcdef", rd); end
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b1, 64'h8, 64'h000000000000DEAD, 2'b01, 1'b0);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, 64'h0, 64'd0, 2'b00, 1'b0);
        n_cmp++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_busy got rdy=%b v=%b exp rdy=0 v=0", req_ready, resp_valid); end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_outputs got rdy=%b v=%b d=%h e=%b exp rdy=1 v=0 d=0 e=0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        do_req(1'b0, 1'b0, 64'h8, 64'd0, 2'b11, 1'b0, rd, er, lat);
        n_cmp++; if (rd !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL rm_no_write got=%h exp=0123456789abcdef", rd); end
    endtask

    task automatic test_lat1_random();
        logic [63:0] rd, wd, ev; logic er; int lat, nb, ai;
        logic [1:0] sz; logic [2:0] lane; bit un;
        for (int p = 0; p < 10; p++) begin
            sz   = 2'($urandom_range(0, 3));
            nb   = 1 << sz;
            lane = 3'($urandom_range(0, 7)) & ~3'(nb - 1);
            ai   = int'($urandom_range(0, 127)) * 8 + int'(lane);
            wd   = {$urandom, $urandom};
            un   = 1'($urandom_range(0, 1));
            do_req(1'b1, 1'b1, 64'(ai), wd, sz, 1'b0, rd, er, lat);
            for (int b = 0; b < nb; b++) model[ai + b] = wd[8*b +: 8];
            n_cmp++; if (lat != 1 || er !== 1'b0) begin n_fail++; $display("FAIL l1_store[%0d] got lat=%0d e=%b exp lat=1 e=0", p, lat, er); end
            ev = '0;
            for (int b = 0; b < nb; b++) ev |= 64'(model[ai + b]) << (8 * b);
            if (!un && nb < 8 && ev[8*nb-1]) ev |= ~((64'd1 << (8 * nb)) - 64'd1);
            do_req(1'b1, 1'b0, 64'(ai), 64'd0, sz, un, rd, er, lat);
            n_cmp++;
            if (lat != 1 || rd !== ev || er !== 1'b0) begin
                n_fail++;
                $display("FAIL l1_load[%0d] addr=%h sz=%0d got lat=%0d d=%h e=%b exp lat=1 d=%h e=0",
                         p, ai, sz, lat, rd, er, ev);
            end
        end
    endtask

    initial begin
        test_reset();
        test_double();
        test_byte();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_lat1_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
